adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_pkg.sv | 25 ++
 rtl/adc_spi_reader_if.sv | 42 ++++
 rtl/spi_tick_gen.sv | 32 +++
 rtl/adc_spi_reader.sv | 164 ++++++++++++++++
 tb/tb_adc_spi_reader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_pkg.sv
// Shared types and frame constants for the SPI ADC reader.
// The frame is 16 SCLK periods: leading zero bits from the ADC followed by the result.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StGap
    } state_e;

    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned LEAD_ZEROS   = 4;
    localparam int unsigned ADDR_MSB_POS = 13;

    // Control word: the 3-bit mux address sits at bits ADDR_MSB_POS..ADDR_MSB_POS-2, rest zero.
    function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [2:0] ch);
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[ADDR_MSB_POS -: 3] = ch;
        return w;
    endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// Request/result and SPI pin bundle between the motor controller, the reader and the ADC.
interface adc_spi_reader_if #(
    parameter int unsigned DATA_W = 12
) ();

    logic              adc_latch;
    logic [2:0]        channel;
    logic [DATA_W-1:0] adc;
    logic              adc_valid;
    logic              busy;
    logic              spi_cs_n;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;

    // Seen from the reader.
    modport slave (
        input  adc_latch,
        input  channel,
        input  spi_miso,
        output adc,
        output adc_valid,
        output busy,
        output spi_cs_n,
        output spi_sclk,
        output spi_mosi
    );

    // Seen from the requester / ADC side.
    modport master (
        output adc_latch,
        output channel,
        output spi_miso,
        input  adc,
        input  adc_valid,
        input  busy,
        input  spi_cs_n,
        input  spi_sclk,
        input  spi_mosi
    );

endinterface

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: pulses once every CLK_DIV cycles while not held clear.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
        if (clear) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/adc_spi_reader.sv
// Converts adc_latch rising edges into one 16-bit SPI frame each (CPOL=1) and
// publishes the result; edges arriving mid-frame collapse into one pending request.
module adc_spi_reader
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 12
) (
    input logic              clk,
    input logic              rst_n,
    adc_spi_reader_if.slave  bus
);

    localparam int unsigned HALF_W  = $clog2(2 * FRAME_BITS);
    localparam int unsigned RX_BITS = FRAME_BITS - LEAD_ZEROS;
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * FRAME_BITS - 1);

    state_e state_q, state_d;

    logic latch_q;
    logic armed_q;
    logic pend_q, pend_d;
    logic cs_n_q, cs_n_d;
    logic sclk_q, sclk_d;
    logic mosi_q, mosi_d;
    logic busy_q, busy_d;
    logic valid_q, valid_d;

    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [RX_BITS-1:0]    rx_q, rx_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [DATA_W-1:0]     adc_q, adc_d;

    logic rise;
    logic tick;
    logic tick_clear;

    // armed_q blocks a false edge when adc_latch is already high as reset releases.
    assign rise       = bus.adc_latch && !latch_q && armed_q;
    assign tick_clear = (state_q == StIdle);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        half_d  = half_q;
        adc_d   = adc_q;

        if (rise && state_q != StIdle) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (rise || pend_q) begin
                    state_d = StCsSetup;
                    pend_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = ctrl_word(bus.channel);
                end
            end
            StCsSetup: begin
                if (tick) begin
                    state_d = StShift;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[FRAME_BITS-1];
                    tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
                    half_d  = '0;
                end
            end
            StShift: begin
                if (tick) begin
                    if (!half_q[0]) begin
                        // End of a low half: SCLK rises and the ADC bit is captured.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[RX_BITS-2:0], bus.spi_miso};
                        half_d = half_q + HALF_W'(1);
                    end else if (half_q == LAST_HALF) begin
                        state_d = StCsHold;
                    end else begin
                        sclk_d = 1'b0;
                        mosi_d = tx_q[FRAME_BITS-1];
                        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                        half_d = half_q + HALF_W'(1);
                    end
                end
            end
            StCsHold: begin
                if (tick) begin
                    state_d = StGap;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    mosi_d  = 1'b0;
                    adc_d   = DATA_W'(rx_q);
                end
            end
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            latch_q <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            half_q  <= '0;
            adc_q   <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= bus.adc_latch;
            armed_q <= armed_q || !bus.adc_latch;
            pend_q  <= pend_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            half_q  <= half_d;
            adc_q   <= adc_d;
        end
    end

    assign bus.adc       = adc_q;
    assign bus.adc_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_sclk  = sclk_q;
    assign bus.spi_mosi  = mosi_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: one instance at CLK_DIV=4, one at CLK_DIV=1, each with an ADC model
// that shifts out four zeros then a 12-bit value, one bit per SCLK period.
module tb_adc_spi_reader;

    localparam int unsigned DATA_W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    adc_spi_reader_if #(.DATA_W(DATA_W)) bus_a ();
    adc_spi_reader_if #(.DATA_W(DATA_W)) bus_b ();

    adc_spi_reader #(
        .CLK_DIV (4),
        .DATA_W  (DATA_W)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (bus_a)
    );

    adc_spi_reader #(
        .CLK_DIV (1),
        .DATA_W  (DATA_W)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (bus_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model and monitor, instance A
    logic [15:0] miso_sr_a   = '0;
    logic [15:0] mosi_cap_a  = '0;
    logic [15:0] last_mosi_a = '0;
    logic [11:0] val_a       = '0;
    logic        prev_cs_a   = 1'b1;
    logic        prev_sclk_a = 1'b1;
    bit          rose_once_a = 1'b0;
    int cs_fall_a = 0, cs_rise_a = 0, cs_falls_a = 0, valid_a = 0, lat_a = 0, rises_a = 0;
    int min_gap_a = 1000;

    assign bus_a.spi_miso = miso_sr_a[15];

    always @(negedge clk) begin
        if (prev_cs_a && !bus_a.spi_cs_n) begin
            cs_fall_a = cyc;
            cs_falls_a++;
            rises_a    = 0;
            mosi_cap_a = '0;
            miso_sr_a  = {4'b0000, val_a};
            if (rose_once_a && (cyc - cs_rise_a) < min_gap_a) min_gap_a = cyc - cs_rise_a;
        end
        if (!prev_cs_a && bus_a.spi_cs_n) begin
            cs_rise_a   = cyc;
            rose_once_a = 1'b1;
            last_mosi_a = mosi_cap_a;
        end
        if (!bus_a.spi_cs_n && !prev_sclk_a && bus_a.spi_sclk) begin
            mosi_cap_a = {mosi_cap_a[14:0], bus_a.spi_mosi};
            miso_sr_a  = {miso_sr_a[14:0], 1'b0};
            rises_a++;
        end
        if (bus_a.adc_valid) begin
            valid_a++;
            lat_a = cyc - cs_fall_a;
        end
        prev_cs_a   = bus_a.spi_cs_n;
        prev_sclk_a = bus_a.spi_sclk;
    end

    // ADC model and monitor, instance B
    logic [15:0] miso_sr_b   = '0;
    logic [11:0] val_b       = '0;
    logic        prev_cs_b   = 1'b1;
    logic        prev_sclk_b = 1'b1;
    int cs_fall_b = 0, valid_b = 0, lat_b = 0, rises_b = 0, last_rise_b = 0, per_b = 0;

    assign bus_b.spi_miso = miso_sr_b[15];

    always @(negedge clk) begin
        if (prev_cs_b && !bus_b.spi_cs_n) begin
            cs_fall_b = cyc;
            rises_b   = 0;
            miso_sr_b = {4'b0000, val_b};
        end
        if (!bus_b.spi_cs_n && !prev_sclk_b && bus_b.spi_sclk) begin
            if (rises_b > 0) per_b = cyc - last_rise_b;
            last_rise_b = cyc;
            miso_sr_b   = {miso_sr_b[14:0], 1'b0};
            rises_b++;
        end
        if (bus_b.adc_valid) begin
            valid_b++;
            lat_b = cyc - cs_fall_b;
        end
        prev_cs_b   = bus_b.spi_cs_n;
        prev_sclk_b = bus_b.spi_sclk;
    end

    task automatic pulse_a();
        bus_a.adc_latch = 1'b1;
        @(negedge clk);
        bus_a.adc_latch = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_b();
        bus_b.adc_latch = 1'b1;
        @(negedge clk);
        bus_b.adc_latch = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid_a(input int target, input int budget);
        for (int i = 0; i < budget && valid_a < target; i++) @(negedge clk);
    endtask

    task automatic wait_valid_b(input int target, input int budget);
        for (int i = 0; i < budget && valid_b < target; i++) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int c0;
        rst_a_n         = 1'b0;
        rst_b_n         = 1'b0;
        bus_a.adc_latch = 1'b0;
        bus_a.channel   = 3'd0;
        bus_b.adc_latch = 1'b0;
        bus_b.channel   = 3'd0;
        repeat (3) @(negedge clk);

        check_eq("rst_cs_n", 32'(bus_a.spi_cs_n), 32'd1);
        check_eq("rst_sclk", 32'(bus_a.spi_sclk), 32'd1);
        check_eq("rst_mosi", 32'(bus_a.spi_mosi), 32'd0);
        check_eq("rst_adc", 32'(bus_a.adc), 32'd0);
        check_eq("rst_valid", 32'(bus_a.adc_valid), 32'd0);
        check_eq("rst_busy", 32'(bus_a.busy), 32'd0);
        check_eq("rst_b_cs_n", 32'(bus_b.spi_cs_n), 32'd1);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single conversion, channel 5, value 2500
        val_a         = 12'h9C4;
        bus_a.channel = 3'd5;
        v0            = valid_a;
        pulse_a();
        check_eq("t1_busy", 32'(bus_a.busy), 32'd1);
        check_eq("t1_cs_low", 32'(bus_a.spi_cs_n), 32'd0);
        wait_valid_a(v0 + 1, 300);
        @(negedge clk);
        check_eq("t1_valid_cnt", 32'(valid_a), 32'(v0 + 1));
        check_eq("t1_adc", 32'(bus_a.adc), 32'd2500);
        check_eq("t1_latency", 32'(lat_a), 32'd136);
        check_eq("t1_mosi_addr", 32'(last_mosi_a[13:11]), 32'b101);
        check_eq("t1_mosi_word", 32'(last_mosi_a), 32'h2800);
        check_eq("t1_busy_gap", 32'(bus_a.busy), 32'd0);
        check_eq("t1_valid_1cyc", 32'(bus_a.adc_valid), 32'd0);

        // Back-to-back conversions through the pending flag: 4000 then 1000
        val_a         = 12'd4000;
        bus_a.channel = 3'd2;
        v0            = valid_a;
        pulse_a();
        wait_valid_a(v0 + 1, 300);
        @(negedge clk);
        check_eq("t2_adc_first", 32'(bus_a.adc), 32'd4000);
        val_a = 12'd1000;
        pulse_a();
        repeat (40) @(negedge clk);
        check_eq("t2_second_active", 32'(bus_a.spi_cs_n), 32'd0);
        check_eq("t2_adc_hold", 32'(bus_a.adc), 32'd4000);
        wait_valid_a(v0 + 2, 300);
        @(negedge clk);
        check_eq("t2_adc_second", 32'(bus_a.adc), 32'd1000);
        check_eq("t2_valid_cnt", 32'(valid_a), 32'(v0 + 2));
        check_eq("t2_cs_gap_ge4", 32'(min_gap_a >= 4), 32'd1);

        // Three edges during busy collapse into one extra conversion; channel taken at acceptance
        val_a         = 12'h123;
        bus_a.channel = 3'd1;
        v0            = valid_a;
        c0            = cs_falls_a;
        pulse_a();
        repeat (10) @(negedge clk);
        pulse_a();
        pulse_a();
        pulse_a();
        bus_a.channel = 3'd6;
        wait_valid_a(v0 + 1, 300);
        @(negedge clk);
        check_eq("t3_mosi_first", 32'(last_mosi_a), 32'h0800);
        wait_valid_a(v0 + 2, 300);
        repeat (200) @(negedge clk);
        check_eq("t3_valid_cnt", 32'(valid_a), 32'(v0 + 2));
        check_eq("t3_frames", 32'(cs_falls_a), 32'(c0 + 2));
        check_eq("t3_mosi_pending", 32'(last_mosi_a), 32'h3000);
        check_eq("t3_adc", 32'(bus_a.adc), 32'h123);

        // Reset in SCLK period 8 aborts the frame
        val_a         = 12'h6A5;
        bus_a.channel = 3'd4;
        v0            = valid_a;
        pulse_a();
        for (int i = 0; i < 300 && !(rises_a >= 7 && !bus_a.spi_sclk); i++) @(negedge clk);
        check_eq("t4_in_frame", 32'(bus_a.spi_cs_n), 32'd0);
        rst_a_n = 1'b0;
        @(negedge clk);
        check_eq("t4_cs_n", 32'(bus_a.spi_cs_n), 32'd1);
        check_eq("t4_sclk", 32'(bus_a.spi_sclk), 32'd1);
        check_eq("t4_adc", 32'(bus_a.adc), 32'd0);
        check_eq("t4_busy", 32'(bus_a.busy), 32'd0);
        check_eq("t4_mosi", 32'(bus_a.spi_mosi), 32'd0);
        rst_a_n = 1'b1;
        repeat (150) @(negedge clk);
        check_eq("t4_no_valid", 32'(valid_a), 32'(v0));
        val_a         = 12'h555;
        bus_a.channel = 3'd3;
        pulse_a();
        wait_valid_a(v0 + 1, 300);
        @(negedge clk);
        check_eq("t4_adc_after", 32'(bus_a.adc), 32'h555);
        check_eq("t4_latency", 32'(lat_a), 32'd136);
        check_eq("t4_mosi", 32'(last_mosi_a), 32'h1800);

        // adc_latch high across reset release must not start a frame
        rst_a_n         = 1'b0;
        bus_a.adc_latch = 1'b1;
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        c0      = cs_falls_a;
        v0      = valid_a;
        repeat (100) @(negedge clk);
        check_eq("t5_no_frame", 32'(cs_falls_a), 32'(c0));
        check_eq("t5_busy", 32'(bus_a.busy), 32'd0);
        bus_a.adc_latch = 1'b0;
        repeat (2) @(negedge clk);
        val_a         = 12'h0F0;
        bus_a.channel = 3'd7;
        pulse_a();
        wait_valid_a(v0 + 1, 300);
        @(negedge clk);
        check_eq("t5_valid_cnt", 32'(valid_a), 32'(v0 + 1));
        check_eq("t5_adc", 32'(bus_a.adc), 32'h0F0);

        // CLK_DIV=1: full-scale then zero
        val_b         = 12'hFFF;
        bus_b.channel = 3'd2;
        v0            = valid_b;
        pulse_b();
        wait_valid_b(v0 + 1, 100);
        @(negedge clk);
        check_eq("t6_adc_fff", 32'(bus_b.adc), 32'hFFF);
        check_eq("t6_latency", 32'(lat_b), 32'd34);
        check_eq("t6_sclk_period", 32'(per_b), 32'd2);
        val_b = 12'h000;
        pulse_b();
        wait_valid_b(v0 + 2, 100);
        @(negedge clk);
        check_eq("t6_valid_cnt", 32'(valid_b), 32'(v0 + 2));
        check_eq("t6_adc_000", 32'(bus_b.adc), 32'h000);
        check_eq("t6_latency2", 32'(lat_b), 32'd34);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
